// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//
// Purpose:
//   Bundles every signal of mem_arbiter except clk/rst.
//   This covers the fetch requester, the LSU requester, the single-port
//   memory bus and the lock status.
//
// Port summary (signal groups):
//   fetch : f_req, f_addr           -> arbiter
//           f_gnt, f_rvalid, f_rdata <- arbiter
//   lsu   : l_req, l_we, l_addr, l_wdata, l_lock -> arbiter
//           l_gnt, l_rvalid, l_rdata             <- arbiter
//   mem   : addr, data_out, we       <- arbiter
//           data_in                  -> arbiter
//   status: locked                   <- arbiter
//
// Modports:
//   slave  - the arbiter's view (requests in, grants/bus out).
//   master - the view of whatever surrounds it: requesters plus memory.
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
  // fetch port (read-only)
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [7:0]  f_rdata;

  // load/store unit port
  logic        l_req;
  logic        l_we;
  logic [15:0] l_addr;
  logic [7:0]  l_wdata;
  logic        l_lock;
  logic        l_gnt;
  logic        l_rvalid;
  logic [7:0]  l_rdata;

  // memory bus
  logic [15:0] addr;
  logic [7:0]  data_out;
  logic        we;
  logic [7:0]  data_in;

  // status
  logic        locked;

  modport slave (
    input  f_req, f_addr,
    input  l_req, l_we, l_addr, l_wdata, l_lock,
    input  data_in,
    output f_gnt, f_rvalid, f_rdata,
    output l_gnt, l_rvalid, l_rdata,
    output addr, data_out, we,
    output locked
  );

  modport master (
    output f_req, f_addr,
    output l_req, l_we, l_addr, l_wdata, l_lock,
    output data_in,
    input  f_gnt, f_rvalid, f_rdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  addr, data_out, we,
    input  locked
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares the core's single 16-bit synchronous memory port between two
//   requesters:
//   - the instruction-fetch frontend, which only reads;
//   - the load/store unit, which reads and writes.
//   The LSU wins by default. A starvation counter lifts fetch above the LSU
//   once fetch has been denied MAX_STARVE cycles in a row. The LSU can lock
//   the bus to itself across a read-modify-write sequence.
//
// Parameters:
//   MAX_STARVE - consecutive denied fetch cycles before fetch wins (1..2^CNT_W-1)
//   CNT_W      - starvation counter width
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - mem_arbiter_if.slave (fetch port, LSU port, memory bus, locked)
//
// Handshake:
//   A requester raises req with its address and data, and holds them until it
//   sees gnt high in the same cycle. gnt means the access is on the memory bus
//   this cycle; a request that is not granted is simply not queued. A granted
//   read returns rvalid exactly one cycle later, with rdata = data_in. Writes
//   never return rvalid. A grant can be issued every cycle.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned MAX_STARVE = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(MAX_STARVE);
  localparam logic [CNT_W-1:0] STARVE_SAT = '1;

  // The lock is the only control state, so it is kept as a two-state FSM.
  // The state is visible outside through bus.locked.
  typedef enum logic {
    LOCK_OFF = 1'b0,
    LOCK_ON  = 1'b1
  } lock_state_e;

  lock_state_e      lock_q, lock_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             f_rvalid_q, f_rvalid_d;
  logic             l_rvalid_q, l_rvalid_d;

  logic             f_gnt;
  logic             l_gnt;

  // -------------------------------------------------------------------------
  // Grant selection. Purely combinational from the requests and the
  // registered lock/starve state, so at most one grant per cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst) begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
    end else if (lock_q == LOCK_ON) begin
      // Fetch is shut out for the whole locked sequence, even during LSU
      // idle cycles. RMW sequences are short, so the starvation bound only
      // stretches by a few cycles.
      l_gnt = bus.l_req;
    end else if (bus.f_req && (starve_q >= STARVE_LIM)) begin
      f_gnt = 1'b1;
    end else if (bus.l_req) begin
      l_gnt = 1'b1;
    end else if (bus.f_req) begin
      f_gnt = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Bus drive. The bus returns to all-zero when nothing is granted, so an
  // idle bus never leaves a stale write enable behind.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.addr     = 16'h0000;
    bus.data_out = 8'h00;
    bus.we       = 1'b0;
    if (f_gnt) begin
      bus.addr = bus.f_addr;
    end else if (l_gnt) begin
      bus.addr     = bus.l_addr;
      bus.data_out = bus.l_wdata;
      bus.we       = bus.l_we;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic: lock FSM, starvation counter, read-return valids.
  // -------------------------------------------------------------------------
  always_comb begin
    lock_d     = lock_q;
    starve_d   = starve_q;
    f_rvalid_d = f_gnt;
    l_rvalid_d = l_gnt & ~bus.l_we;

    // The lock only moves on an LSU grant. Each granted access restates
    // whether the bus stays locked after it.
    case (lock_q)
      LOCK_OFF: if (l_gnt && bus.l_lock)  lock_d = LOCK_ON;
      LOCK_ON:  if (l_gnt && !bus.l_lock) lock_d = LOCK_OFF;
      default:  lock_d = LOCK_OFF;
    endcase

    // The counter measures consecutive denied fetch cycles, including cycles
    // denied by the lock. It saturates so that a long lock cannot wrap it
    // back below the threshold.
    if (!bus.f_req || f_gnt) begin
      starve_d = '0;
    end else if (starve_q != STARVE_SAT) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q     <= LOCK_OFF;
      starve_q   <= '0;
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      starve_q   <= starve_d;
      f_rvalid_q <= f_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.f_gnt    = f_gnt;
  assign bus.l_gnt    = l_gnt;
  assign bus.f_rvalid = f_rvalid_q;
  assign bus.l_rvalid = l_rvalid_q;
  // Read data passes straight through. The memory already registers it, so
  // it lines up with the registered rvalid.
  assign bus.f_rdata  = bus.data_in;
  assign bus.l_rdata  = bus.data_in;
  assign bus.locked   = (lock_q == LOCK_ON);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter (MAX_STARVE=4, CNT_W=3).
// A single process models a synchronous single-port memory: the address is
// sampled on the rising edge and read data appears on data_in in the
// following cycle. Inputs change 1 time unit after the rising edge, and
// outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .MAX_STARVE (4),
    .CNT_W      (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [7:0] mem [0:65535];

  initial begin
    logic [7:0] rd;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hC000] = 8'hA9;
    mem[16'h1000] = 8'h11;
    mem[16'h2000] = 8'h22;
    mem[16'h0010] = 8'h77;
    bus.data_in = 8'h00;
    forever begin
      @(posedge clk);
      rd = mem[bus.addr];
      if (bus.we) mem[bus.addr] = bus.data_out;
      bus.data_in <= rd;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.f_req   = 1'b0;
    bus.f_addr  = 16'h0000;
    bus.l_req   = 1'b0;
    bus.l_we    = 1'b0;
    bus.l_addr  = 16'h0000;
    bus.l_wdata = 8'h00;
    bus.l_lock  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic       exp_f, exp_l, prev_f, prev_l;
    logic [5:0] rmw_lreq, rmw_we, rmw_lock, rmw_fgnt, rmw_locked;

    n_checks = 0;
    n_fails  = 0;
    idle_inputs();
    rst = 1'b1;
    next_cycle();

    // ---- reset with both requesting ----
    bus.f_req  = 1'b1;
    bus.l_req  = 1'b1;
    bus.f_addr = 16'h1234;
    bus.l_addr = 16'h5678;
    bus.l_we   = 1'b1;
    bus.l_wdata = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      mid_cycle();
      check("rst_f_gnt", 32'(bus.f_gnt), 32'd0);
      check("rst_l_gnt", 32'(bus.l_gnt), 32'd0);
      check("rst_addr",  32'(bus.addr), 32'd0);
      check("rst_we",    32'(bus.we), 32'd0);
      check("rst_dout",  32'(bus.data_out), 32'd0);
      next_cycle();
    end
    rst = 1'b0;
    idle_inputs();
    mid_cycle();
    check("post_rst_f_rvalid", 32'(bus.f_rvalid), 32'd0);
    check("post_rst_l_rvalid", 32'(bus.l_rvalid), 32'd0);
    check("post_rst_locked",   32'(bus.locked), 32'd0);
    check("idle_addr",         32'(bus.addr), 32'd0);
    next_cycle();

    // ---- fetch only ----
    bus.f_req  = 1'b1;
    bus.f_addr = 16'hC000;
    mid_cycle();
    check("fetch_f_gnt", 32'(bus.f_gnt), 32'd1);
    check("fetch_l_gnt", 32'(bus.l_gnt), 32'd0);
    check("fetch_addr",  32'(bus.addr), 32'h0000C000);
    check("fetch_we",    32'(bus.we), 32'd0);
    next_cycle();
    idle_inputs();
    mid_cycle();
    check("fetch_f_rvalid", 32'(bus.f_rvalid), 32'd1);
    check("fetch_f_rdata",  32'(bus.f_rdata), 32'h000000A9);
    check("fetch_l_rvalid", 32'(bus.l_rvalid), 32'd0);
    next_cycle();

    // ---- contention and starvation ----
    bus.f_req  = 1'b1;
    bus.f_addr = 16'h1000;
    bus.l_req  = 1'b1;
    bus.l_we   = 1'b0;
    bus.l_addr = 16'h2000;
    prev_f = 1'b0;
    prev_l = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_f = (i == 4) || (i == 9);
      exp_l = !exp_f;
      mid_cycle();
      check($sformatf("starve_f_gnt_%0d", i), 32'(bus.f_gnt), 32'(exp_f));
      check($sformatf("starve_l_gnt_%0d", i), 32'(bus.l_gnt), 32'(exp_l));
      check($sformatf("starve_addr_%0d", i), 32'(bus.addr), exp_f ? 32'h1000 : 32'h2000);
      check($sformatf("starve_f_rvalid_%0d", i), 32'(bus.f_rvalid), 32'(prev_f));
      check($sformatf("starve_l_rvalid_%0d", i), 32'(bus.l_rvalid), 32'(prev_l));
      if (prev_f || prev_l)
        check($sformatf("starve_rdata_%0d", i), 32'(bus.l_rdata), prev_f ? 32'h11 : 32'h22);
      prev_f = exp_f;
      prev_l = exp_l;
      next_cycle();
    end
    idle_inputs();
    mid_cycle();
    check("starve_tail_f_rvalid", 32'(bus.f_rvalid), 32'd1);
    check("starve_tail_l_rvalid", 32'(bus.l_rvalid), 32'd0);
    check("starve_tail_f_rdata",  32'(bus.f_rdata), 32'h11);
    next_cycle();

    // ---- LSU write, then read it back ----
    bus.l_req   = 1'b1;
    bus.l_we    = 1'b1;
    bus.l_addr  = 16'h0200;
    bus.l_wdata = 8'h5A;
    mid_cycle();
    check("wr_l_gnt", 32'(bus.l_gnt), 32'd1);
    check("wr_addr",  32'(bus.addr), 32'h0200);
    check("wr_dout",  32'(bus.data_out), 32'h5A);
    check("wr_we",    32'(bus.we), 32'd1);
    next_cycle();
    bus.l_we    = 1'b0;
    bus.l_wdata = 8'h00;
    mid_cycle();
    check("wr_l_rvalid", 32'(bus.l_rvalid), 32'd0);
    check("rb_we",       32'(bus.we), 32'd0);
    check("rb_l_gnt",    32'(bus.l_gnt), 32'd1);
    next_cycle();
    idle_inputs();
    mid_cycle();
    check("rb_l_rvalid", 32'(bus.l_rvalid), 32'd1);
    check("rb_l_rdata",  32'(bus.l_rdata), 32'h5A);
    check("idle_we",     32'(bus.we), 32'd0);
    next_cycle();

    // ---- RMW lock with fetch held high ----
    // cycle:       5 4 3 2 1 0
    rmw_lreq   = 6'b011001;
    rmw_we     = 6'b011000;
    rmw_lock   = 6'b001001;
    rmw_fgnt   = 6'b100000;
    rmw_locked = 6'b011110;
    bus.f_req  = 1'b1;
    bus.f_addr = 16'h3000;
    for (int i = 0; i < 6; i++) begin
      bus.l_req   = rmw_lreq[i];
      bus.l_we    = rmw_we[i];
      bus.l_lock  = rmw_lock[i];
      bus.l_addr  = rmw_lreq[i] ? 16'h0010 : 16'h0000;
      bus.l_wdata = rmw_we[i] ? 8'h78 : 8'h00;
      mid_cycle();
      check($sformatf("rmw_f_gnt_%0d", i),  32'(bus.f_gnt), 32'(rmw_fgnt[i]));
      check($sformatf("rmw_l_gnt_%0d", i),  32'(bus.l_gnt), 32'(rmw_lreq[i]));
      check($sformatf("rmw_locked_%0d", i), 32'(bus.locked), 32'(rmw_locked[i]));
      check($sformatf("rmw_we_%0d", i),     32'(bus.we), 32'(rmw_we[i]));
      if (i == 1) begin
        check("rmw_rd_rvalid", 32'(bus.l_rvalid), 32'd1);
        check("rmw_rd_rdata",  32'(bus.l_rdata), 32'h77);
      end
      if (i == 5) check("rmw_f_addr", 32'(bus.addr), 32'h3000);
      next_cycle();
    end
    idle_inputs();
    mid_cycle();
    check("rmw_tail_f_rvalid", 32'(bus.f_rvalid), 32'd1);
    check("rmw_tail_locked",   32'(bus.locked), 32'd0);
    next_cycle();

    // ---- reset mid-lock with a read in flight ----
    bus.l_req  = 1'b1;
    bus.l_lock = 1'b1;
    bus.l_addr = 16'h0010;
    mid_cycle();
    check("rml_gnt0", 32'(bus.l_gnt), 32'd1);
    next_cycle();
    mid_cycle();
    check("rml_gnt1",   32'(bus.l_gnt), 32'd1);
    check("rml_locked", 32'(bus.locked), 32'd1);
    next_cycle();
    rst = 1'b1;
    mid_cycle();
    check("rml_rst_l_gnt",  32'(bus.l_gnt), 32'd0);
    check("rml_rst_addr",   32'(bus.addr), 32'd0);
    check("rml_rst_rvalid", 32'(bus.l_rvalid), 32'd1);
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    bus.f_req  = 1'b1;
    bus.f_addr = 16'hC000;
    mid_cycle();
    check("rml_post_locked",   32'(bus.locked), 32'd0);
    check("rml_post_l_rvalid", 32'(bus.l_rvalid), 32'd0);
    check("rml_post_f_gnt",    32'(bus.f_gnt), 32'd1);
    next_cycle();
    idle_inputs();
    mid_cycle();
    check("rml_f_rvalid", 32'(bus.f_rvalid), 32'd1);
    check("rml_f_rdata",  32'(bus.f_rdata), 32'h000000A9);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port arbiter for the core's one 16-bit memory bus: the `addr`/`data_out`/`we` outputs and the `data_in` input.
- Shares the bus between two requesters inside `core`: the frontend instruction-fetch port (read-only) and the load/store unit (read/write).
- The LSU has priority by default. A starvation counter guarantees fetch forward progress.
- A lock input lets the LSU hold the bus across 6502 read-modify-write sequences.

Parameters:
- MAX_STARVE, 4: number of consecutive cycles fetch may be denied before it wins priority. Legal range 1..2^CNT_W-1.
- CNT_W, 3: width of the starvation counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- f_req  in  1  fetch requests a read this cycle.
- f_addr  in  16  fetch read address.
- f_gnt  out  1  fetch access is placed on the bus this cycle.
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  8  fetch read data.
- l_req  in  1  LSU requests an access this cycle.
- l_we  in  1  1 = write, 0 = read.
- l_addr  in  16  LSU address.
- l_wdata  in  8  LSU write data.
- l_lock  in  1  keep the bus locked to the LSU after this access.
- l_gnt  out  1  LSU access is placed on the bus this cycle.
- l_rvalid  out  1  LSU read data valid.
- l_rdata  out  8  LSU read data.
- addr  out  16  memory address bus.
- data_out  out  8  memory write data.
- we  out  1  memory write enable.
- data_in  in  8  memory read data; valid the cycle after the read address is presented.
- locked  out  1  status: bus is currently locked to the LSU.

Behaviour:
- Memory model: synchronous single port.
  - Address and we are sampled at the edge ending cycle N.
  - Read data appears on `data_in` during cycle N+1.
  - Writes complete at that edge.
- Grant logic is combinational from the inputs and the registered state `lock_q` and `starve_q`. Exactly one or zero grants per cycle.

Grant priority, evaluated in order:
1. rst=1: no grant.
2. lock_q=1: grant LSU if l_req, otherwise no grant. Fetch is never granted while locked.
3. f_req and starve_q >= MAX_STARVE: grant fetch.
4. l_req: grant LSU.
5. f_req: grant fetch.
6. Otherwise: no grant.

Bus drive:
- Fetch granted: addr=f_addr, we=0, data_out=0.
- LSU granted: addr=l_addr, we=l_we, data_out=l_wdata.
- No grant, or rst: addr=0, we=0, data_out=0.

Read return:
- f_rvalid_q <= f_gnt.
- l_rvalid_q <= l_gnt & ~l_we.
- f_rdata = l_rdata = data_in, combinational pass-through. Only meaningful while the matching rvalid is high.
- Read latency is 1 cycle from grant. A write produces no rvalid.
- Back-to-back grants are allowed every cycle; there are no bubbles.

lock_q:
- Set when l_gnt & l_lock.
- Cleared when l_gnt & ~l_lock.
- Otherwise holds, including when the LSU is idle while locked.
- `locked` = lock_q.

starve_q:
- Reset to 0 when f_gnt, or when ~f_req.
- Increments by 1, saturating at 2^CNT_W-1, when f_req & ~f_gnt. This includes cycles denied because of the lock.

Reset:
- Synchronous; takes effect at the edge where rst=1.
- lock_q=0, starve_q=0, f_rvalid=0, l_rvalid=0.
- While rst=1, all grants and bus outputs are forced to 0.
- Reset mid-lock drops the lock. Reset mid-read suppresses the pending rvalid on the following cycle.

Simultaneous events:
- Both requesters active: the loser's request is not queued. The requester must hold req and its address until it sees gnt.
- Lock set and starvation threshold reached in the same cycle: lock wins. Fetch may starve beyond MAX_STARVE while locked; RMW sequences are at most 3 accesses.

Test Plan:
- Reset and idle:
  - Stimulus: rst=1 for 2 cycles with f_req=l_req=1.
  - Required: f_gnt=l_gnt=0, addr=0, we=0 throughout. After rst is released, f_rvalid=l_rvalid=0 and locked=0.
- Fetch only:
  - Stimulus: f_req=1, f_addr=16'hC000, memory returns 8'hA9.
  - Required: f_gnt=1 and addr=C000 in cycle N; f_rvalid=1 and f_rdata=A9 in cycle N+1.
- Contention and starvation, MAX_STARVE=4:
  - Stimulus: f_req and l_req (reads) held high continuously.
  - Required: l_gnt in cycles 0-3, f_gnt in cycle 4, l_gnt in cycles 5-8, f_gnt in cycle 9.
  - Each l_rvalid/f_rvalid follows its grant by exactly 1 cycle.
- LSU write:
  - Stimulus: l_req=1, l_we=1, l_addr=16'h0200, l_wdata=8'h5A.
  - Required: addr=0200, data_out=5A, we=1 for one cycle; l_rvalid stays 0.
- RMW lock:
  - Stimulus: LSU issues read $0010 (lock=1), idles 2 cycles, writes $0010 (lock=1), then writes $0010 (lock=0), with f_req held high throughout.
  - Required: locked=1 from the cycle after the first grant until the final write's edge.
  - f_gnt=0 for all 5 cycles, including the idle ones, even though starve_q reaches 4.
  - f_gnt=1 in the cycle after the unlock.
- Reset mid-lock:
  - Stimulus: assert rst for 1 cycle while locked=1 and a read was granted in the previous cycle.
  - Required: locked=0 after the edge; no l_rvalid from the killed read in the cycle after reset; fetch is granted on the next f_req.
